bcd_converter: RTL and testbench
================================

BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 The block SHALL have parameter SRC_W, default 24: width of the raw SPI word input.
REQ-002 The block SHALL have parameter SRC_LSB, default 8: bit index of the LSB of the binary field within the raw word.
REQ-003 The block SHALL have parameter BIN_W, default 16: binary field width, 1..32, with SRC_LSB+BIN_W <= SRC_W.
REQ-004 The block SHALL have parameter DIGITS, default 4: number of BCD output digits, 1..9.
REQ-005 The block SHALL have parameter SIGNED, default 0: 1 = binary field is two's complement, 0 = unsigned.
REQ-006 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 spi_data  in  SRC_W  raw SPI word; binary field = spi_data[SRC_LSB +: BIN_W].
REQ-009 in_valid  in  1  spi_data is presented for conversion.
REQ-010 in_ready  out  1  block is idle and can accept a word.
REQ-011 bcd_values  out  4*DIGITS  result; digit k SHALL occupy bits [4k+3:4k], with k=0 the least significant digit.
REQ-012 sign  out  1  result is negative (SIGNED=1 only; SHALL be tied 0 when SIGNED=0).
REQ-013 overflow  out  1  magnitude exceeded 10^DIGITS-1; the result is saturated.
REQ-014 out_valid  out  1  one-cycle pulse marking a new result on bcd_values/sign/overflow.

Function
REQ-015 The FSM SHALL have states IDLE and SHIFT; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept: at an edge with in_valid=1 in IDLE, the block SHALL capture the binary field, set the bit counter to BIN_W and go to SHIFT.
REQ-017 In SHIFT, per edge: add 3 to every scratch BCD digit >= 5, then left-shift scratch:magnitude by 1, then decrement the counter (double-dabble, one bit per cycle).
REQ-018 The scratch register SHALL hold enough digits for the full BIN_W magnitude, independent of DIGITS.
REQ-019 Magnitude: SIGNED=0 -> field as unsigned; SIGNED=1 and field MSB=1 -> two's-complement negation computed in BIN_W+1 bits, so that -2^(BIN_W-1) converts correctly.
REQ-020 Latency: if accept occurs at edge E, bcd_values, sign and overflow SHALL update and out_valid SHALL rise at edge E+BIN_W.
REQ-021 At edge E+BIN_W the FSM SHALL return to IDLE; the earliest next accept SHALL be edge E+BIN_W+1 (throughput 1 word per BIN_W+1 cycles).
REQ-022 out_valid SHALL be high for exactly one cycle per accepted word.
REQ-023 bcd_values, sign and overflow SHALL hold their values until the next result edge.
REQ-024 Overflow: magnitude > 10^DIGITS-1 SHALL give overflow=1 and every digit = 4'h9; otherwise overflow=0 and the digits equal the exact decimal value.
REQ-025 sign SHALL be 1 iff SIGNED=1 and the captured field is negative; zero SHALL give sign=0.
REQ-026 in_valid during SHIFT SHALL be ignored without being queued; changes of spi_data after accept SHALL NOT affect the result in progress.
REQ-027 A conversion in progress SHALL run to completion; there is no abort other than rst.

Reset
REQ-028 While rst=1, the block SHALL immediately, without waiting for clk, force FSM=IDLE, counter=0, scratch=0, bcd_values=0, sign=0, overflow=0 and out_valid=0.
REQ-029 While rst=1, in_ready SHALL be 0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-030 rst asserted mid-conversion SHALL discard the word in progress and SHALL produce no out_valid pulse for it.

Verification
REQ-031 Defaults, spi_data=24'h04D2xx (1234), one-cycle in_valid -> after 16 cycles out_valid=1, bcd_values=16'h1234, overflow=0, sign=0.
REQ-032 Defaults, field=16'hFFFF (65535) -> bcd_values=16'h9999, overflow=1; then field=9999 -> 16'h9999, overflow=0.
REQ-033 SIGNED=1, BIN_W=16, DIGITS=5, field=16'h8000 -> sign=1, bcd_values=20'h32768, overflow=0; field=0 -> sign=0, bcd_values=0.
REQ-034 in_valid held high continuously with changing data -> accepts exactly every 17 cycles, one out_valid per accept, each result matches the word captured at its accept.
REQ-035 rst pulsed 5 cycles after an accept -> all outputs 0 immediately, no out_valid for that word; the next word converts correctly.
REQ-036 Randomised unsigned fields, all parameter corners (BIN_W=1/32, DIGITS=1/9) -> results match the reference model, including the overflow saturation boundary at 10^DIGITS-1 and 10^DIGITS.

Source files
------------

// File: rtl/bcd_converter.sv
// Serial binary-to-BCD converter: extracts a binary field from a raw SPI word and
// converts it with double-dabble, one bit per clock, saturating to all nines.
module bcd_converter #(
    parameter int unsigned SRC_W   = 24,
    parameter int unsigned SRC_LSB = 8,
    parameter int unsigned BIN_W   = 16,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned SIGNED  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SRC_W-1:0]      spi_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_values,
    output logic                  sign,
    output logic                  overflow,
    output logic                  out_valid
);

    // Decimal digits of 2^BIN_W: floor(BIN_W*log10(2)) + 1, covers any BIN_W-bit magnitude.
    localparam int unsigned SCR_D = (BIN_W * 30103) / 100000 + 1;
    localparam int unsigned SCR_W = 4 * SCR_D;
    localparam int unsigned OUT_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCR_W-1:0]   scr_q;
    logic [BIN_W-1:0]   mag_q;
    logic               neg_q;
    logic               ready_q;
    logic               valid_q;
    logic [OUT_W-1:0]   bcd_q;
    logic               sign_q;
    logic               ovf_q;

    logic [BIN_W-1:0]   field_c;
    logic [BIN_W:0]     neg_c;
    logic               field_neg_c;
    logic [BIN_W-1:0]   mag_in_c;
    logic [SCR_W-1:0]   scr_adj_c;
    logic [SCR_W-1:0]   scr_d;
    logic [BIN_W-1:0]   mag_d;
    logic [OUT_W-1:0]   res_bcd_c;
    logic               res_ovf_c;
    logic               unused_bits;

    // Field extraction and magnitude; negation is one bit wider so -2^(BIN_W-1) survives.
    always_comb begin
        field_c     = spi_data[SRC_LSB +: BIN_W];
        field_neg_c = (SIGNED != 0) && field_c[BIN_W-1];
        neg_c       = -{1'b0, field_c};
        mag_in_c    = field_neg_c ? neg_c[BIN_W-1:0] : field_c;
    end

    assign unused_bits = ^{spi_data, neg_c[BIN_W]};

    // One double-dabble step: add 3 to digits >= 5, then shift scratch:magnitude left.
    always_comb begin
        scr_adj_c = scr_q;
        for (int k = 0; k < int'(SCR_D); k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj_c[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
        {scr_d, mag_d} = {scr_adj_c, mag_q} << 1;
    end

    // Digits beyond the output width mean the value exceeds 10^DIGITS-1.
    if (SCR_D > DIGITS) begin : g_ovf
        assign res_bcd_c = scr_d[OUT_W-1:0];
        assign res_ovf_c = |scr_d[SCR_W-1:OUT_W];
    end else begin : g_no_ovf
        assign res_bcd_c = OUT_W'(scr_d);
        assign res_ovf_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scr_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (in_valid && ready_q) begin
                        state_q <= SHIFT;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_W'(BIN_W);
                        scr_q   <= '0;
                        mag_q   <= mag_in_c;
                        neg_q   <= field_neg_c;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last bit: publish the result and become ready on the same edge.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        bcd_q   <= res_ovf_c ? {DIGITS{4'h9}} : res_bcd_c;
                        ovf_q   <= res_ovf_c;
                        sign_q  <= neg_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = valid_q;
    assign bcd_values = bcd_q;
    assign sign       = sign_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: five parameter corners, arithmetic reference model,
// scoreboard queue of expected results popped on each out_valid.
module tb_bcd_converter;

    localparam int N = 5;
    localparam int BW [N] = '{16, 16, 1, 32, 32};
    localparam int DG [N] = '{4, 5, 1, 9, 1};
    localparam int LS [N] = '{8, 8, 2, 0, 4};
    localparam int SG [N] = '{0, 1, 0, 0, 0};

    typedef struct packed {
        logic [35:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_bad;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] spi [N];
    logic        iv  [N];
    logic        rdy [N];
    logic        ovl [N];
    logic        sgn [N];
    logic        ofl [N];
    logic [35:0] bcdw [N];
    logic [15:0] b0;
    logic [19:0] b1;
    logic [3:0]  b2;
    logic [35:0] b3;
    logic [3:0]  b4;
    logic        tb_unused;

    always #5 clk = ~clk;

    always_comb begin
        bcdw[0] = 36'(b0);
        bcdw[1] = 36'(b1);
        bcdw[2] = 36'(b2);
        bcdw[3] = b3;
        bcdw[4] = 36'(b4);
    end

    assign tb_unused = ^{spi[0][39:24], spi[1][39:24], spi[2][39:4], spi[3][39:32]};

    bcd_converter #(.SRC_W(24), .SRC_LSB(8), .BIN_W(16), .DIGITS(4), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .spi_data(spi[0][23:0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .bcd_values(b0), .sign(sgn[0]), .overflow(ofl[0]), .out_valid(ovl[0]));
    bcd_converter #(.SRC_W(24), .SRC_LSB(8), .BIN_W(16), .DIGITS(5), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .spi_data(spi[1][23:0]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .bcd_values(b1), .sign(sgn[1]), .overflow(ofl[1]), .out_valid(ovl[1]));
    bcd_converter #(.SRC_W(4), .SRC_LSB(2), .BIN_W(1), .DIGITS(1), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .spi_data(spi[2][3:0]), .in_valid(iv[2]), .in_ready(rdy[2]),
        .bcd_values(b2), .sign(sgn[2]), .overflow(ofl[2]), .out_valid(ovl[2]));
    bcd_converter #(.SRC_W(32), .SRC_LSB(0), .BIN_W(32), .DIGITS(9), .SIGNED(0)) u3 (
        .clk(clk), .rst(rst), .spi_data(spi[3][31:0]), .in_valid(iv[3]), .in_ready(rdy[3]),
        .bcd_values(b3), .sign(sgn[3]), .overflow(ofl[3]), .out_valid(ovl[3]));
    bcd_converter #(.SRC_W(40), .SRC_LSB(4), .BIN_W(32), .DIGITS(1), .SIGNED(0)) u4 (
        .clk(clk), .rst(rst), .spi_data(spi[4]), .in_valid(iv[4]), .in_ready(rdy[4]),
        .bcd_values(b4), .sign(sgn[4]), .overflow(ofl[4]), .out_valid(ovl[4]));

    // Reference: extract field, take magnitude arithmetically, peel decimal digits.
    function automatic exp_t model(input int id, input logic [39:0] word);
        longint unsigned f, mag, lim, msk;
        exp_t e;
        msk = (64'd1 << BW[id]) - 64'd1;
        f   = (64'(word) >> LS[id]) & msk;
        e   = '0;
        mag = f;
        if (SG[id] != 0 && ((f >> (BW[id] - 1)) & 64'd1) == 64'd1) begin
            mag    = (64'd1 << BW[id]) - f;
            e.sign = 1'b1;
        end
        lim = 64'd1;
        for (int i = 0; i < DG[id]; i++) lim = lim * 64'd10;
        e.ovf = (mag >= lim);
        for (int i = 0; i < DG[id]; i++) begin
            e.bcd[4*i +: 4] = e.ovf ? 4'h9 : 4'(mag % 64'd10);
            mag = mag / 64'd10;
        end
        return e;
    endfunction

    // Raw word with random bits around the field.
    function automatic logic [39:0] mk(input int id, input longint unsigned field);
        logic [63:0] r, msk;
        r   = {$urandom(), $urandom()};
        msk = ((64'd1 << BW[id]) - 64'd1) << LS[id];
        r   = (r & ~msk) | ((field << LS[id]) & msk);
        return r[39:0];
    endfunction

    task automatic convert(input int id, input logic [39:0] word);
        exp_t e, got;
        int   lat;
        bit   seen;
        e = model(id, word);
        @(negedge clk);
        n_vec++;
        if (rdy[id] !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_accept id=%0d got %b want 1", id, rdy[id]);
        end
        spi[id] = word;
        iv[id]  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        iv[id]  = 1'b0;
        spi[id] = ~word;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat <= BW[id] + 4) begin
            if (ovl[id] === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL timeout id=%0d got no out_valid want one within %0d cycles", id, BW[id] + 4);
            sb.delete();
        end else begin
            got = sb.pop_front();
            if (lat != BW[id]) begin
                n_bad++;
                $display("FAIL latency id=%0d got %0d want %0d", id, lat, BW[id]);
            end
            n_vec++;
            if (bcdw[id] !== got.bcd) begin
                n_bad++;
                $display("FAIL bcd id=%0d word=%h got %h want %h", id, word, bcdw[id], got.bcd);
            end
            n_vec++;
            if (sgn[id] !== got.sign || ofl[id] !== got.ovf) begin
                n_bad++;
                $display("FAIL sign_ovf id=%0d word=%h got %b%b want %b%b", id, word,
                         sgn[id], ofl[id], got.sign, got.ovf);
            end
            @(negedge clk);
            n_vec++;
            if (ovl[id] !== 1'b0 || rdy[id] !== 1'b1 || bcdw[id] !== got.bcd) begin
                n_bad++;
                $display("FAIL pulse_hold id=%0d got ov=%b rdy=%b bcd=%h want ov=0 rdy=1 bcd=%h",
                         id, ovl[id], rdy[id], bcdw[id], got.bcd);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                n_vec++;
                if ({rdy[i], ovl[i], ofl[i], sgn[i], bcdw[i]} !== '0) begin
                    n_bad++;
                    $display("FAIL reset_outputs id=%0d got rdy=%b ov=%b ovf=%b sign=%b bcd=%h want all 0",
                             i, rdy[i], ovl[i], ofl[i], sgn[i], bcdw[i]);
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        convert(0, mk(0, 1234));
        convert(0, mk(0, 65535));
        convert(0, mk(0, 9999));
        convert(0, mk(0, 10000));
        convert(0, mk(0, 0));
        convert(0, mk(0, 1));
    endtask

    task automatic test_signed;
        convert(1, mk(1, 64'h8000));
        convert(1, mk(1, 0));
        convert(1, mk(1, 64'hFFFF));
        convert(1, mk(1, 64'h7FFF));
        convert(1, mk(1, 64'hFB2E));
    endtask

    task automatic test_corners;
        convert(2, mk(2, 0));
        convert(2, mk(2, 1));
        convert(3, mk(3, 999999999));
        convert(3, mk(3, 1000000000));
        convert(3, mk(3, 64'hFFFF_FFFF));
        convert(3, mk(3, 0));
        convert(4, mk(4, 9));
        convert(4, mk(4, 10));
        convert(4, mk(4, 64'hFFFF_FFFF));
        convert(4, mk(4, 0));
    endtask

    // in_valid held high: accepts at 0, 17, 34; results seen at 17, 34, 51.
    task automatic test_back_to_back;
        logic [39:0] w;
        exp_t        got;
        for (int k = 0; k <= 51; k++) begin
            @(negedge clk);
            n_vec++;
            if (ovl[0] !== ((k > 0 && k % 17 == 0) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL b2b_valid k=%0d got %b want %b", k, ovl[0], (k > 0 && k % 17 == 0));
            end
            if (ovl[0] === 1'b1 && sb.size() > 0) begin
                got = sb.pop_front();
                n_vec++;
                if (bcdw[0] !== got.bcd || ofl[0] !== got.ovf) begin
                    n_bad++;
                    $display("FAIL b2b_result k=%0d got %h/%b want %h/%b", k, bcdw[0], ofl[0], got.bcd, got.ovf);
                end
            end
            n_vec++;
            if (rdy[0] !== ((k % 17 == 0) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL b2b_ready k=%0d got %b want %b", k, rdy[0], (k % 17 == 0));
            end
            w      = mk(0, longint'($urandom_range(0, 65535)));
            spi[0] = w;
            iv[0]  = (k < 51);
            if (k % 17 == 0 && k < 51) sb.push_back(model(0, w));
        end
        iv[0] = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        convert(0, mk(0, 1234));
        @(negedge clk);
        spi[0] = mk(0, 5678);
        iv[0]  = 1'b1;
        @(negedge clk);
        iv[0]  = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({rdy[0], ovl[0], ofl[0], sgn[0], bcdw[0]} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got rdy=%b ov=%b ovf=%b sign=%b bcd=%h want all 0",
                     rdy[0], ovl[0], ofl[0], sgn[0], bcdw[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (ovl[0] === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL discarded_word got %0d pulses want 0", pulses);
        end
        convert(0, mk(0, 4321));
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            convert(0, mk(0, longint'($urandom_range(0, 65535))));
            convert(1, mk(1, longint'($urandom_range(0, 65535))));
            convert(3, mk(3, longint'($urandom())));
            convert(4, mk(4, longint'($urandom_range(0, 20))));
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < N; i++) begin
            spi[i] = '0;
            iv[i]  = 1'b0;
        end
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
